alu_rr_arbiter: RTL and testbench

- Shares one combinational 16-bit ALU between two requesters (ALU ports: a, b, cin, opcode[2:0], out, zero, neg).
- Accepts operations over valid/ready handshakes and grants the ALU round-robin.
- Drives the ALU from registered operands, captures the result with its flags, and returns it on a single response channel tagged with the requester ID.
- Sits between the issue logic (two command sources) and the shared ALU instance.

---
 rtl/alu_rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// Round-robin front end that shares one combinational ALU between two command sources.
// Optional grant/error counters are enabled by defining ALU_ARB_STATS_EN.
module alu_rr_arbiter #(
    parameter int W = 16,
    parameter int OPW = 3,
    parameter logic [OPW-1:0] ILLEGAL_OPC = 3'd7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req0_b,
    input  logic [W-1:0]   req1_b,
    input  logic           req0_cin,
    input  logic           req1_cin,
    input  logic [OPW-1:0] req0_opc,
    input  logic [OPW-1:0] req1_opc,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic           alu_cin,
    output logic [OPW-1:0] alu_opc,
    input  logic [W-1:0]   alu_out,
    input  logic           alu_zero,
    input  logic           alu_neg,
`ifdef ALU_ARB_STATS_EN
    output logic [15:0]    grant_cnt0,
    output logic [15:0]    grant_cnt1,
    output logic [7:0]     err_cnt,
`endif
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_zero,
    output logic           rsp_neg,
    output logic           rsp_err,
    output logic           rsp_id
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state;
    logic   rr_ptr;
    logic   op_id_p0;
    logic   grant;
    logic   grant_vld;
    logic   accept;
    logic   illegal_p0;

    // Preferred requester wins when valid, otherwise the other one may take the slot.
    always_comb begin
        grant_vld = 1'b0;
        grant     = rr_ptr;
        if (req_valid[rr_ptr]) begin
            grant_vld = 1'b1;
            grant     = rr_ptr;
        end else if (req_valid[~rr_ptr]) begin
            grant_vld = 1'b1;
            grant     = ~rr_ptr;
        end
    end

    assign accept     = (state == IDLE) && grant_vld;
    assign illegal_p0 = (alu_opc == ILLEGAL_OPC);
    assign req_ready  = (rst_n && accept) ? (grant ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            op_id_p0  <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cin   <= 1'b0;
            alu_opc   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_neg   <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_id    <= 1'b0;
        end else begin
            case (state)
                // Issue: operand registers double as the ALU drive and hold until the next accept.
                IDLE: begin
                    if (grant_vld) begin
                        alu_a    <= grant ? req1_a   : req0_a;
                        alu_b    <= grant ? req1_b   : req0_b;
                        alu_cin  <= grant ? req1_cin : req0_cin;
                        alu_opc  <= grant ? req1_opc : req0_opc;
                        op_id_p0 <= grant;
                        rr_ptr   <= ~grant;
                        state    <= EXEC;
                    end
                end
                // Execute: ALU settles during this cycle, result captured at its end.
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= op_id_p0;
                    if (illegal_p0) begin
                        rsp_data <= '0;
                        rsp_zero <= 1'b0;
                        rsp_neg  <= 1'b0;
                        rsp_err  <= 1'b1;
                    end else begin
                        rsp_data <= alu_out;
                        rsp_zero <= alu_zero;
                        rsp_neg  <= alu_neg;
                        rsp_err  <= 1'b0;
                    end
                    state <= RESP;
                end
                // Respond: hold until the consumer takes it.
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            err_cnt    <= '0;
        end else begin
            if (accept && !grant && grant_cnt0 != 16'hFFFF)
                grant_cnt0 <= grant_cnt0 + 16'd1;
            if (accept && grant && grant_cnt1 != 16'hFFFF)
                grant_cnt1 <= grant_cnt1 + 16'd1;
            if (state == EXEC && illegal_p0 && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: vector table, hand sequences and a randomized run
// against a transaction-level model. Stats checks compile in with ALU_ARB_STATS_EN.
module tb_alu_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready;
    logic [15:0] req0_a, req1_a, req0_b, req1_b;
    logic        req0_cin, req1_cin;
    logic [2:0]  req0_opc, req1_opc;
    logic [15:0] alu_a, alu_b, alu_out;
    logic        alu_cin, alu_zero, alu_neg;
    logic [2:0]  alu_opc;
    logic        rsp_valid, rsp_ready, rsp_zero, rsp_neg, rsp_err, rsp_id;
    logic [15:0] rsp_data;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1;
    logic [7:0]  err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    alu_rr_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
        .req0_cin(req0_cin), .req1_cin(req1_cin),
        .req0_opc(req0_opc), .req1_opc(req1_opc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_opc(alu_opc),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_neg(alu_neg),
`ifdef ALU_ARB_STATS_EN
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .err_cnt(err_cnt),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_neg(rsp_neg), .rsp_err(rsp_err), .rsp_id(rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU; opcode 7 returns junk that the arbiter must discard.
    function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic cin, input logic [2:0] opc);
        case (opc)
            3'd0: return a + b + {15'd0, cin};
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << 1;
            3'd6: return a >> 1;
            default: return 16'hDEAD;
        endcase
    endfunction

    assign alu_out  = alu_fn(alu_a, alu_b, alu_cin, alu_opc);
    assign alu_zero = (alu_out == 16'd0);
    assign alu_neg  = alu_out[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout expected=event", name);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Polls at negedge+1 until req_ready is nonzero; returns 0 on timeout.
    task automatic wait_ready(output bit ok);
        int n = 0;
        ok = 1'b0;
        while (req_ready == 2'b00 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = (req_ready != 2'b00);
    endtask

    typedef struct {
        logic [1:0]  vld;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [2:0]  opc;
        logic [15:0] data;
        logic        zero;
        logic        neg;
        logic        err;
    } vec_t;

    vec_t vecs[10];

    task automatic set_ops(input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic [2:0] opc, input logic sel);
        req0_a = sel ? ~a : a;   req1_a = sel ? a : ~a;
        req0_b = sel ? ~b : b;   req1_b = sel ? b : ~b;
        req0_cin = sel ? ~cin : cin;  req1_cin = sel ? cin : ~cin;
        req0_opc = sel ? 3'd6 : opc;  req1_opc = sel ? opc : 3'd6;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        set_ops(v.a, v.b, v.cin, v.opc, v.vld[1]);
        req_valid = v.vld;
        rsp_ready = 1'b1;
        #1 chk("vec_ready", {30'd0, req_ready}, {30'd0, v.vld});
        @(negedge clk);
        req_valid = 2'b00;
        set_ops(~v.a, ~v.b, ~v.cin, 3'd3, v.vld[1]);
        #1;
        chk("vec_alu_a", {16'd0, alu_a}, {16'd0, v.a});
        chk("vec_alu_b", {16'd0, alu_b}, {16'd0, v.b});
        chk("vec_alu_cin_opc", {28'd0, alu_cin, alu_opc}, {28'd0, v.cin, v.opc});
        chk("vec_rsp_early", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk("vec_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("vec_rsp_data", {16'd0, rsp_data}, {16'd0, v.data});
        chk("vec_rsp_flags", {28'd0, rsp_zero, rsp_neg, rsp_err, rsp_id},
            {28'd0, v.zero, v.neg, v.err, v.vld[1]});
        @(negedge clk);
        #1 chk("vec_rsp_done", {31'd0, rsp_valid}, 32'd0);
    endtask

    // Transaction-level model state for the random run.
    bit          m_free, m_busy, m_have_rsp, m_pref;
    logic [15:0] m_a, m_b, m_data;
    logic        m_cin, m_id, m_zero, m_neg, m_err;
    logic [2:0]  m_opc;

    initial begin
        bit ok;
        int last;
        logic [1:0] exp_rdy;
        logic       g;
        bit         any;

        vecs[0] = '{2'b01, 16'h0003, 16'h0005, 1'b0, 3'd0, 16'h0008, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{2'b10, 16'hFFFF, 16'h0001, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{2'b01, 16'h0005, 16'h0007, 1'b0, 3'd1, 16'hFFFE, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{2'b10, 16'hF0F0, 16'hFF00, 1'b0, 3'd2, 16'hF000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{2'b01, 16'h00F0, 16'h0F00, 1'b0, 3'd3, 16'h0FF0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{2'b10, 16'hFFFF, 16'hFFFF, 1'b0, 3'd4, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{2'b01, 16'h8000, 16'h0000, 1'b1, 3'd0, 16'h8001, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{2'b10, 16'hFFFF, 16'h1234, 1'b1, 3'd7, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{2'b10, 16'h4001, 16'h0000, 1'b0, 3'd5, 16'h8002, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{2'b01, 16'h8001, 16'h0000, 1'b0, 3'd6, 16'h4000, 1'b0, 1'b0, 1'b0};

        set_ops(16'h0, 16'h0, 1'b0, 3'd0, 1'b0);
        do_reset();
        #1;
        chk("rst_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rsp", {12'd0, rsp_valid, rsp_data, rsp_zero, rsp_neg, rsp_err, rsp_id}, 32'd0);
        chk("rst_alu", {12'd0, alu_a, alu_cin, alu_opc}, 32'd0);
        chk("rst_alu_b", {16'd0, alu_b}, 32'd0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Contention: alternating grants, one accept every 3 cycles.
        do_reset();
        @(negedge clk);
        set_ops(16'h0011, 16'h0022, 1'b0, 3'd0, 1'b0);
        req1_a = 16'h0100; req1_b = 16'h0200; req1_opc = 3'd0; req1_cin = 1'b0;
        req_valid = 2'b11;
        #1;
        last = 0;
        for (int i = 0; i < 6; i++) begin
            wait_ready(ok);
            if (!ok) fail_now("cont_wait");
            chk("cont_grant", {30'd0, req_ready}, (i % 2) ? 32'd2 : 32'd1);
            if (i > 0) chk("cont_gap", cyc - last, 32'd3);
            last = cyc;
            @(negedge clk); #1;
            @(negedge clk); #1;
            chk("cont_rsp_id", {30'd0, rsp_valid, rsp_id}, (i % 2) ? 32'd3 : 32'd2);
            chk("cont_rsp_data", {16'd0, rsp_data}, (i % 2) ? 32'h0300 : 32'h0033);
            @(negedge clk); #1;
        end
        req_valid = 2'b00;

        // Backpressure: response held, no accepts, release returns to IDLE.
        do_reset();
        @(negedge clk);
        rsp_ready = 1'b0;
        set_ops(16'h1234, 16'h1111, 1'b0, 3'd0, 1'b0);
        req_valid = 2'b01;
        #1 chk("bp_ready", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 2'b11;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold", {12'd0, rsp_valid, rsp_data, rsp_id, req_ready, 1'b0},
                {12'd0, 1'b1, 16'h2345, 1'b0, 2'b00, 1'b0});
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1 chk("bp_release", {30'd0, rsp_valid, req_ready == 2'b10}, 32'd1);
        req_valid = 2'b00;

        // Reset during EXEC drops the op and restarts arbitration at requester 0.
        do_reset();
        @(negedge clk);
        set_ops(16'hABCD, 16'h5555, 1'b1, 3'd4, 1'b0);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        #1 chk("mr_exec_alu", {16'd0, alu_a}, 32'h0000ABCD);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("mr_alu", {12'd0, alu_a, alu_cin, alu_opc}, 32'd0);
        chk("mr_alu_b", {16'd0, alu_b}, 32'd0);
        chk("mr_ready", {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 2'b11;
        #1 chk("mr_first_grant", {30'd0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        #1 chk("mr_no_rsp_after", {31'd0, rsp_valid}, 32'd0);
        req_valid = 2'b00;

`ifdef ALU_ARB_STATS_EN
        do_reset();
        #1 chk("st_reset", {grant_cnt0, grant_cnt1[7:0], err_cnt}, 32'd0);
        run_vec(vecs[0]);
        run_vec(vecs[2]);
        run_vec(vecs[1]);
        run_vec(vecs[3]);
        vecs[4].vld = 2'b01;
        vecs[7].vld = 2'b01;
        vecs[7].b = 16'h0000;
        run_vec(vecs[7]);
        #1;
        chk("st_cnt0", {16'd0, grant_cnt0}, 32'd3);
        chk("st_cnt1", {16'd0, grant_cnt1}, 32'd2);
        chk("st_err", {24'd0, err_cnt}, 32'd1);
`endif

        // Randomized run against the transaction model.
        do_reset();
        m_free = 1; m_busy = 0; m_have_rsp = 0; m_pref = 0;
        m_a = '0; m_b = '0; m_cin = 0; m_opc = '0; m_id = 0;
        m_data = '0; m_zero = 0; m_neg = 0; m_err = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req_valid = 2'($urandom_range(0, 3));
            rsp_ready = ($urandom_range(0, 3) != 0);
            req0_a = 16'($urandom); req1_a = 16'($urandom);
            req0_b = 16'($urandom); req1_b = 16'($urandom);
            req0_cin = 1'($urandom); req1_cin = 1'($urandom);
            req0_opc = 3'($urandom); req1_opc = 3'($urandom);
            #1;
            any = m_free && (req_valid != 2'b00);
            g = req_valid[m_pref] ? m_pref : ~m_pref;
            exp_rdy = any ? (g ? 2'b10 : 2'b01) : 2'b00;
            chk("rnd_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
            chk("rnd_valid", {31'd0, rsp_valid}, {31'd0, m_have_rsp});
            chk("rnd_alu", {12'd0, alu_a, alu_cin, alu_opc}, {12'd0, m_a, m_cin, m_opc});
            if (m_have_rsp)
                chk("rnd_rsp", {12'd0, rsp_data, rsp_zero, rsp_neg, rsp_err, rsp_id},
                    {12'd0, m_data, m_zero, m_neg, m_err, m_id});
            if (m_have_rsp) begin
                if (rsp_ready) begin
                    m_have_rsp = 0;
                    m_free = 1;
                end
            end else if (m_busy) begin
                m_busy = 0;
                m_have_rsp = 1;
                m_err  = (m_opc == 3'd7);
                m_data = m_err ? 16'd0 : alu_fn(m_a, m_b, m_cin, m_opc);
                m_zero = !m_err && (m_data == 16'd0);
                m_neg  = m_data[15];
            end else if (any) begin
                m_free = 0;
                m_busy = 1;
                m_id   = g;
                m_pref = ~g;
                m_a    = g ? req1_a : req0_a;
                m_b    = g ? req1_b : req0_b;
                m_cin  = g ? req1_cin : req0_cin;
                m_opc  = g ? req1_opc : req0_opc;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
